// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared command codes, operand addresses and decoder states
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_OP_A    = 3'd4,
    S_OP_B    = 3'd5,
    S_ALU_FUN = 3'd6
  } state_e;
endpackage

// File: rtl/sys_ctrl_tmo_cnt.sv
// sys_ctrl_tmo_cnt: inter-byte idle counter that pulses o_expire when a frame stalls
module sys_ctrl_tmo_cnt #(
  parameter int TMO_WD = 16,
  parameter logic [TMO_WD-1:0] TMO_CYC = 16'd50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam logic [TMO_WD-1:0] LIM = TMO_CYC - 1'b1;
  logic [TMO_WD-1:0] r_cnt;
  // an arriving byte (i_clr) always beats expiry in the same cycle
  assign o_expire = i_en & ~i_clr & (r_cnt == LIM);
  always_ff @(posedge CLK) begin
    if (RST || i_clr || !i_en || o_expire) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/sys_ctrl_rx_decoder.sv
// sys_ctrl_rx_decoder: decodes UART command frames into register-file and ALU strobes
module sys_ctrl_rx_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4,
  parameter int FUN_WD = 4,
  parameter int TMO_WD = 16,
  parameter logic [TMO_WD-1:0] TMO_CYC = 16'd50000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] RX_P_DATA,
  input  logic               RX_D_VLD,
  input  logic               PAR_ERR,
  input  logic               STP_ERR,
  output logic               WrEn,
  output logic               RdEn,
  output logic [ADDR_WD-1:0] Address,
  output logic [DATA_WD-1:0] WrData,
  output logic               ALU_EN,
  output logic [FUN_WD-1:0]  ALU_FUN,
  output logic               CLK_GATE_EN,
  output logic               FRAME_ERR
);
  state_e r_state, w_nxt;
  logic r_wr, r_rd, r_alu, r_ferr;
  logic [ADDR_WD-1:0] r_wr_addr, r_addr, w_wr_addr;
  logic [DATA_WD-1:0] r_wdata;
  logic [FUN_WD-1:0] r_fun;
  logic w_acc, w_err, w_exp, w_cmd, w_wr, w_rd, w_alu;
  assign w_err = RX_D_VLD & (PAR_ERR | STP_ERR);
  assign w_acc = RX_D_VLD & ~(PAR_ERR | STP_ERR);
  assign w_cmd = RX_P_DATA inside {CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP};
  assign w_wr = w_acc & (r_state inside {S_WR_DATA, S_OP_A, S_OP_B});
  assign w_rd = w_acc & (r_state == S_RD_ADDR);
  assign w_alu = w_acc & (r_state == S_ALU_FUN);
  assign w_wr_addr = r_state == S_WR_DATA ? r_wr_addr :
                     r_state == S_OP_A ? ADDR_WD'(OPA_ADDR) : ADDR_WD'(OPB_ADDR);
  sys_ctrl_tmo_cnt #(.TMO_WD(TMO_WD), .TMO_CYC(TMO_CYC)) u_tmo (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (RX_D_VLD),
    .i_en     (r_state != S_IDLE),
    .o_expire (w_exp)
  );
  always_comb begin
    w_nxt = r_state;
    if (w_err || w_exp) w_nxt = S_IDLE;
    else if (w_acc)
      case (r_state)
        S_IDLE:    w_nxt = RX_P_DATA == CMD_RF_WR  ? S_WR_ADDR :
                           RX_P_DATA == CMD_RF_RD  ? S_RD_ADDR :
                           RX_P_DATA == CMD_ALU_OP ? S_OP_A :
                           RX_P_DATA == CMD_ALU_NOP ? S_ALU_FUN : S_IDLE;
        S_WR_ADDR: w_nxt = S_WR_DATA;
        S_OP_A:    w_nxt = S_OP_B;
        S_OP_B:    w_nxt = S_ALU_FUN;
        default:   w_nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_alu     <= 1'b0;
      r_ferr    <= 1'b0;
      r_wr_addr <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_fun     <= '0;
    end else begin
      r_state <= w_nxt;
      r_wr    <= w_wr;
      r_rd    <= w_rd;
      r_alu   <= w_alu;
      r_ferr  <= w_err | w_exp | (w_acc & (r_state == S_IDLE) & ~w_cmd);
      if (w_acc && r_state == S_WR_ADDR) r_wr_addr <= RX_P_DATA[ADDR_WD-1:0];
      if (w_wr) r_addr <= w_wr_addr;
      else if (w_rd) r_addr <= RX_P_DATA[ADDR_WD-1:0];
      if (w_wr) r_wdata <= RX_P_DATA;
      if (w_alu) r_fun <= RX_P_DATA[FUN_WD-1:0];
    end
  end
  assign WrEn        = r_wr;
  assign RdEn        = r_rd;
  assign ALU_EN      = r_alu;
  assign FRAME_ERR   = r_ferr;
  assign Address     = r_addr;
  assign WrData      = r_wdata;
  assign ALU_FUN     = r_fun;
  assign CLK_GATE_EN = r_alu | (r_state inside {S_OP_A, S_OP_B, S_ALU_FUN});
endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// tb_sys_ctrl_rx_decoder: directed and randomized checks of the frame decoder against a frame-level model
module tb_sys_ctrl_rx_decoder;
  localparam int TMO = 8;
  logic CLK = 1'b0, RST = 1'b1, RX_D_VLD = 1'b0, PAR_ERR = 1'b0, STP_ERR = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic WrEn, RdEn, ALU_EN, CLK_GATE_EN, FRAME_ERR;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_cmd;
  int m_pos, m_gap;
  logic [3:0] m_addr;
  logic e_wr, e_rd, e_alu, e_ferr, e_cg;
  logic [3:0] e_a, e_fun;
  logic [7:0] e_wd;

  always #5 CLK = ~CLK;

  sys_ctrl_rx_decoder #(.TMO_CYC(16'd8)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .FRAME_ERR(FRAME_ERR)
  );

  function automatic logic [20:0] obs();
    return {WrEn, RdEn, ALU_EN, FRAME_ERR, CLK_GATE_EN, Address, WrData, ALU_FUN};
  endfunction
  function automatic logic [20:0] expv();
    return {e_wr, e_rd, e_alu, e_ferr, e_cg, e_a, e_wd, e_fun};
  endfunction

  // frame-level model: pending command byte plus count of payload bytes seen
  task automatic model(input logic rst, input logic vld, input logic pe, input logic se, input logic [7:0] d);
    {e_wr, e_rd, e_alu, e_ferr} = 4'b0;
    if (rst) begin
      m_cmd = 8'h00; m_pos = 0; m_gap = 0; m_addr = 4'h0; e_a = 4'h0; e_wd = 8'h00; e_fun = 4'h0;
    end else if (vld) begin
      m_gap = 0;
      if (pe || se) begin e_ferr = 1'b1; m_cmd = 8'h00; end
      else if (m_cmd == 8'h00) begin
        if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) begin m_cmd = d; m_pos = 0; end
        else e_ferr = 1'b1;
      end
      else if (m_cmd == 8'hAA && m_pos == 0) begin m_addr = d[3:0]; m_pos = 1; end
      else if (m_cmd == 8'hAA) begin e_wr = 1'b1; e_a = m_addr; e_wd = d; m_cmd = 8'h00; end
      else if (m_cmd == 8'hBB) begin e_rd = 1'b1; e_a = d[3:0]; m_cmd = 8'h00; end
      else if (m_cmd == 8'hCC && m_pos < 2) begin e_wr = 1'b1; e_a = 4'(m_pos); e_wd = d; m_pos++; end
      else begin e_alu = 1'b1; e_fun = d[3:0]; m_cmd = 8'h00; end
    end else if (m_cmd != 8'h00) begin
      if (m_gap == TMO - 1) begin e_ferr = 1'b1; m_cmd = 8'h00; m_gap = 0; end
      else m_gap++;
    end
    e_cg = e_alu || m_cmd == 8'hCC || m_cmd == 8'hDD;
  endtask

  task automatic step(input logic rst, input logic vld, input logic pe, input logic se, input logic [7:0] d);
    RST = rst; RX_D_VLD = vld; PAR_ERR = pe; STP_ERR = se; RX_P_DATA = d;
    @(posedge CLK);
    model(rst, vld, pe, se, d);
    #1;
  endtask
  task automatic send(input logic [7:0] d); step(1'b0, 1'b1, 1'b0, 1'b0, d); endtask
  task automatic idle(); step(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom)); endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
      n_chk++; if (obs() !== 21'h0) begin n_fail++; $display("FAIL reset_cycle%0d: got %h expected 0", i, obs()); end
    end
    idle();
    n_chk++; if (obs() !== 21'h0) begin n_fail++; $display("FAIL reset_after: got %h expected 0", obs()); end
  endtask

  task automatic test_write();
    send(8'hAA); send(8'h05);
    n_chk++; if (WrEn !== 1'b0) begin n_fail++; $display("FAIL wr_early: WrEn got %b expected 0", WrEn); end
    send(8'h3C);
    n_chk++; if ({WrEn, Address, WrData, FRAME_ERR, RdEn, ALU_EN} !== {1'b1, 4'h5, 8'h3C, 3'b000}) begin
      n_fail++; $display("FAIL wr_pulse: got %b/%h/%h/%b%b%b expected 1/5/3c/000", WrEn, Address, WrData, FRAME_ERR, RdEn, ALU_EN);
    end
    idle();
    n_chk++; if ({WrEn, FRAME_ERR, Address, WrData} !== {2'b00, 4'h5, 8'h3C}) begin
      n_fail++; $display("FAIL wr_end: got %b%b/%h/%h expected 00/5/3c", WrEn, FRAME_ERR, Address, WrData);
    end
  endtask

  task automatic test_read();
    send(8'hBB); send(8'h0A);
    n_chk++; if ({RdEn, Address, WrEn, ALU_EN} !== {1'b1, 4'hA, 2'b00}) begin
      n_fail++; $display("FAIL rd_pulse: got %b/%h/%b%b expected 1/a/00", RdEn, Address, WrEn, ALU_EN);
    end
    idle();
    n_chk++; if ({RdEn, Address} !== {1'b0, 4'hA}) begin
      n_fail++; $display("FAIL rd_end: got %b/%h expected 0/a", RdEn, Address);
    end
  endtask

  task automatic test_alu();
    send(8'hCC);
    n_chk++; if ({CLK_GATE_EN, WrEn} !== 2'b10) begin n_fail++; $display("FAIL alu_cg_start: got %b%b expected 10", CLK_GATE_EN, WrEn); end
    send(8'h12);
    n_chk++; if ({WrEn, Address, WrData, CLK_GATE_EN} !== {1'b1, 4'h0, 8'h12, 1'b1}) begin
      n_fail++; $display("FAIL alu_opa: got %b/%h/%h/%b expected 1/0/12/1", WrEn, Address, WrData, CLK_GATE_EN);
    end
    send(8'h34);
    n_chk++; if ({WrEn, Address, WrData, CLK_GATE_EN} !== {1'b1, 4'h1, 8'h34, 1'b1}) begin
      n_fail++; $display("FAIL alu_opb: got %b/%h/%h/%b expected 1/1/34/1", WrEn, Address, WrData, CLK_GATE_EN);
    end
    send(8'h02);
    n_chk++; if ({ALU_EN, ALU_FUN, CLK_GATE_EN, WrEn} !== {1'b1, 4'h2, 2'b10}) begin
      n_fail++; $display("FAIL alu_en: got %b/%h/%b%b expected 1/2/10", ALU_EN, ALU_FUN, CLK_GATE_EN, WrEn);
    end
    idle();
    n_chk++; if ({ALU_EN, CLK_GATE_EN, WrData, ALU_FUN} !== {2'b00, 8'h34, 4'h2}) begin
      n_fail++; $display("FAIL alu_end: got %b%b/%h/%h expected 00/34/2", ALU_EN, CLK_GATE_EN, WrData, ALU_FUN);
    end
  endtask

  task automatic test_error();
    send(8'hAA); send(8'h03);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
    n_chk++; if ({WrEn, FRAME_ERR} !== 2'b01) begin n_fail++; $display("FAIL err_par: got %b%b expected 01", WrEn, FRAME_ERR); end
    send(8'hDD);
    n_chk++; if ({FRAME_ERR, CLK_GATE_EN} !== 2'b01) begin n_fail++; $display("FAIL err_recover: got %b%b expected 01", FRAME_ERR, CLK_GATE_EN); end
    send(8'h07);
    n_chk++; if ({ALU_EN, ALU_FUN, FRAME_ERR} !== {1'b1, 4'h7, 1'b0}) begin
      n_fail++; $display("FAIL err_nop_alu: got %b/%h/%b expected 1/7/0", ALU_EN, ALU_FUN, FRAME_ERR);
    end
    send(8'hBB);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    n_chk++; if ({RdEn, FRAME_ERR} !== 2'b01) begin n_fail++; $display("FAIL err_stp: got %b%b expected 01", RdEn, FRAME_ERR); end
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    n_chk++; if (FRAME_ERR !== 1'b1) begin n_fail++; $display("FAIL err_idle: got %b expected 1", FRAME_ERR); end
    send(8'h05);
    n_chk++; if (FRAME_ERR !== 1'b1) begin n_fail++; $display("FAIL err_dropped_cmd: got %b expected 1", FRAME_ERR); end
  endtask

  task automatic test_timeout();
    send(8'hAA);
    for (int i = 1; i < TMO; i++) begin
      idle();
      n_chk++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL tmo_early%0d: got %b expected 0", i, FRAME_ERR); end
    end
    idle();
    n_chk++; if (FRAME_ERR !== 1'b1) begin n_fail++; $display("FAIL tmo_expire: got %b expected 1", FRAME_ERR); end
    idle();
    n_chk++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 0", FRAME_ERR); end
    send(8'hBB); send(8'h05);
    n_chk++; if ({RdEn, Address} !== {1'b1, 4'h5}) begin n_fail++; $display("FAIL tmo_idle: got %b/%h expected 1/5", RdEn, Address); end
    send(8'hAA);
    for (int i = 1; i < TMO; i++) idle();
    send(8'h09);
    n_chk++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL tmo_race: got %b expected 0", FRAME_ERR); end
    send(8'h77);
    n_chk++; if ({WrEn, Address, WrData, FRAME_ERR} !== {1'b1, 4'h9, 8'h77, 1'b0}) begin
      n_fail++; $display("FAIL tmo_race_wr: got %b/%h/%h/%b expected 1/9/77/0", WrEn, Address, WrData, FRAME_ERR);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hCC); send(8'h11);
    n_chk++; if ({WrEn, Address, WrData} !== {1'b1, 4'h0, 8'h11}) begin
      n_fail++; $display("FAIL rst_mid_opa: got %b/%h/%h expected 1/0/11", WrEn, Address, WrData);
    end
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++; if (obs() !== 21'h0) begin n_fail++; $display("FAIL rst_mid_clear: got %h expected 0", obs()); end
    send(8'h22);
    n_chk++; if ({FRAME_ERR, WrEn, ALU_EN, CLK_GATE_EN} !== 4'b1000) begin
      n_fail++; $display("FAIL rst_mid_22: got %b%b%b%b expected 1000", FRAME_ERR, WrEn, ALU_EN, CLK_GATE_EN);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [10] = '{8'hAA, 8'h01, 8'h11, 8'hAA, 8'h02, 8'h22, 8'hBB, 8'h03, 8'hDD, 8'h05};
    for (int i = 0; i < 10; i++) begin
      send(seq[i]);
      n_chk++; if (obs() !== expv()) begin n_fail++; $display("FAIL b2b byte%0d: got %h expected %h", i, obs(), expv()); end
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] d;
    logic r, v, pe, se;
    int quiet = 0;
    int k;
    for (int i = 0; i < 800; i++) begin
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 19) == 0) quiet = $urandom_range(4, 12);
      k = $urandom_range(0, 7);
      d = k < 4 ? cmds[k] : 8'($urandom);
      v = quiet == 0 && $urandom_range(0, 3) != 0;
      pe = $urandom_range(0, 24) == 0;
      se = $urandom_range(0, 24) == 0;
      r = $urandom_range(0, 199) == 0;
      step(r, v, pe, se, d);
      n_chk++; if (obs() !== expv()) begin n_fail++; $display("FAIL random cycle%0d: got %h expected %h", i, obs(), expv()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
